// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the bit-serial adder/subtractor tile.
//   - state_t     : operation FSM states (IDLE, RUN, DONE)
//   - UI_*        : bit positions inside ui_in
//   - UIO_*       : bit positions inside uio_out
//   - UIO_OE      : constant output-enable pattern for the bidirectional pins
//   - ctl_req_t   : decoded view of ui_in
//   - decode_ui() : ui_in -> ctl_req_t
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // ui_in bit map
  localparam int UI_A     = 0;
  localparam int UI_B     = 1;
  localparam int UI_CIN   = 2;
  localparam int UI_START = 3;
  localparam int UI_VALID = 4;
  localparam int UI_SUB   = 5;

  // uio_out bit map
  localparam int UIO_COUT = 0;
  localparam int UIO_DONE = 1;
  localparam int UIO_BUSY = 2;
  localparam int UIO_OVF  = 3;

  // Low nibble of uio drives status, high nibble stays input.
  localparam logic [7:0] UIO_OE = 8'h0F;

  typedef struct packed {
    logic sub;
    logic valid;
    logic start;
    logic cin;
    logic b;
    logic a;
  } ctl_req_t;

  function automatic ctl_req_t decode_ui(input logic [7:0] ui);
    ctl_req_t r;
    r.a     = ui[UI_A];
    r.b     = ui[UI_B];
    r.cin   = ui[UI_CIN];
    r.start = ui[UI_START];
    r.valid = ui[UI_VALID];
    r.sub   = ui[UI_SUB];
    return r;
  endfunction

endpackage

// File: rtl/tt_um_serial_adder_full_adder_bit.sv
// full_adder_bit
//   Single-bit combinational full adder; the arithmetic core of the
//   serial datapath.
//   Ports:
//     a, b, cin : input bits
//     s         : sum bit  = a ^ b ^ cin
//     cout      : carry    = majority(a, b, cin)
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/tt_um_serial_adder.sv
// tt_um_serial_adder
//   Bit-serial WIDTH-bit adder/subtractor, Tiny Tapeout top level.
//   Operands arrive LSB-first, one (a, b) pair per valid cycle after a start.
//   A registered carry chains the bits; the sum is assembled in a shift
//   register that fills from the MSB end so bit 0 lands last at position 0.
//
//   Parameters:
//     WIDTH   : operand/result width, 2..8
//   Ports:
//     clk     : clock, rising edge
//     rst_n   : asynchronous active-low reset
//     ena     : clock enable, all state holds when low
//     ui_in   : [0] a, [1] b, [2] cin, [3] start, [4] valid, [5] sub
//     uo_out  : result, zero-extended above WIDTH
//     uio_in  : unused
//     uio_out : [0] cout, [1] done, [2] busy, [3] ovf, [7:4] 0
//     uio_oe  : constant 8'h0F
//
//   Build option: SERIAL_ADDER_SUB_EN enables subtract mode (ui_in[5]
//   latched at start; b inverted and cin acts as borrow-in). Without it
//   the block is add-only and ui_in[5] is ignored.
module tt_um_serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  ctl_req_t req;
  assign req = decode_ui(ui_in);

  state_t           state;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] result;
  logic             cout_q;
  logic             ovf_q;
  logic             sub_q;

  // Effective subtract request at start, and the b operand as seen by
  // the adder (inverted for subtraction: a - b = a + ~b + 1).
  logic sub_in;
  logic b_eff;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_in = req.sub;
  assign b_eff  = req.b ^ sub_q;
  wire unused_ok = &{1'b0, uio_in, ui_in[7:6]};
`else
  assign sub_in = 1'b0;
  assign b_eff  = req.b;
  wire unused_ok = &{1'b0, uio_in, ui_in[7:5], sub_q};
`endif

  logic fa_s;
  logic fa_co;

  full_adder_bit u_fa (
    .a    (req.a),
    .b    (b_eff),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_co)
  );

  // start wins over valid and restarts from any state, including RUN.
  // In subtract mode cin is a borrow-in, so the initial carry is ~cin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      sub_q  <= 1'b0;
    end else if (ena) begin
      if (req.start) begin
        state  <= RUN;
        carry  <= req.cin ^ sub_in;
        cnt    <= '0;
        result <= '0;
        cout_q <= 1'b0;
        ovf_q  <= 1'b0;
        sub_q  <= sub_in;
      end else if (state == RUN && req.valid) begin
        carry  <= fa_co;
        result <= {fa_s, result[WIDTH-1:1]};
        cnt    <= cnt + 1'b1;
        if (cnt == LAST) begin
          // Signed overflow: carry into the MSB differs from carry out.
          cout_q <= fa_co;
          ovf_q  <= carry ^ fa_co;
          state  <= DONE;
        end
      end
    end
  end

  assign uo_out = 8'(result);
  assign uio_oe = UIO_OE;

  always_comb begin
    uio_out           = 8'h00;
    uio_out[UIO_COUT] = cout_q;
    uio_out[UIO_DONE] = (state == DONE);
    uio_out[UIO_BUSY] = (state == RUN);
    uio_out[UIO_OVF]  = ovf_q;
  end

endmodule

// File: tb/tb_tt_um_serial_adder.sv
module tb_tt_um_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui8, ui4;
  logic [7:0] uo8, uo4;
  logic [7:0] uio_in8, uio_in4;
  logic [7:0] uio_o8, uio_o4;
  logic [7:0] oe8, oe4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tt_um_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui8), .uo_out(uo8),
    .uio_in(uio_in8), .uio_out(uio_o8), .uio_oe(oe8)
  );

  tt_um_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui4), .uo_out(uo4),
    .uio_in(uio_in4), .uio_out(uio_o4), .uio_oe(oe4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int w, input logic [7:0] v);
    if (w == 8) ui8 = v;
    else        ui4 = v;
  endtask

  function automatic logic [7:0] get_uo(input int w);
    return (w == 8) ? uo8 : uo4;
  endfunction

  function automatic logic [7:0] get_uio(input int w);
    return (w == 8) ? uio_o8 : uio_o4;
  endfunction

  // Reference: whole-word two's-complement arithmetic.
  task automatic model(input int w, input int a, input int b, input bit cin, input bit sub,
                       output int r, output bit co, output bit ov);
    int mask, bb, sum, msb;
    bit c0, sub_eff;
`ifdef SERIAL_ADDER_SUB_EN
    sub_eff = sub;
`else
    sub_eff = 1'b0;
`endif
    mask = (1 << w) - 1;
    msb  = 1 << (w - 1);
    bb   = sub_eff ? (~b & mask) : (b & mask);
    c0   = sub_eff ? !cin : cin;
    sum  = (a & mask) + bb + int'(c0);
    r    = sum & mask;
    co   = ((sum >> w) & 1) != 0;
    ov   = (((a & msb) != 0) == ((bb & msb) != 0)) && (((r & msb) != 0) != ((a & msb) != 0));
  endtask

  function automatic logic [7:0] mk(input bit a, input bit b, input bit cin,
                                    input bit start, input bit valid, input bit sub);
    logic [7:0] v;
    v = 8'h00;
    v[0] = a; v[1] = b; v[2] = cin; v[3] = start; v[4] = valid; v[5] = sub;
    return v;
  endfunction

  // gap_mode: 0 back-to-back, 1 random valid/ena gaps, 2 fixed gap before bit 4
  task automatic op(input string tag, input int w, input int a, input int b,
                    input bit cin, input bit sub, input int gap_mode);
    int  r;
    bit  co, ov;
    logic [7:0] st;
    model(w, a, b, cin, sub, r, co, ov);
    drive(w, mk(1'b0, 1'b0, cin, 1'b1, 1'b1, sub));
    tick();
    chk({tag, ".busy_start"}, 32'(get_uio(w)[2]), 32'd1);
    for (int i = 0; i < w; i++) begin
      int idle_n, ena_n;
      idle_n = 0; ena_n = 0;
      if (gap_mode == 1) begin
        idle_n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
        ena_n  = ($urandom_range(0, 5) == 0) ? 1 : 0;
      end else if (gap_mode == 2 && i == 4) begin
        idle_n = 3; ena_n = 2;
      end
      for (int g = 0; g < idle_n; g++) begin
        drive(w, mk(1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0));
        tick();
        chk({tag, ".busy_gap"}, 32'(get_uio(w)[2]), 32'd1);
      end
      for (int g = 0; g < ena_n; g++) begin
        ena = 1'b0;
        drive(w, mk(1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b1, 1'b0));
        tick();
        chk({tag, ".busy_ena"}, 32'(get_uio(w)[2]), 32'd1);
      end
      ena = 1'b1;
      drive(w, mk(1'((a >> i) & 1), 1'((b >> i) & 1), 1'b0, 1'b0, 1'b1, 1'b0));
      tick();
      if (i == w - 2) chk({tag, ".done_early"}, 32'(get_uio(w)[1]), 32'd0);
    end
    drive(w, 8'h00);
    st = get_uio(w);
    chk({tag, ".result"}, 32'(get_uo(w)), 32'(r));
    chk({tag, ".cout"},   32'(st[0]), 32'(co));
    chk({tag, ".ovf"},    32'(st[3]), 32'(ov));
    chk({tag, ".done"},   32'(st[1]), 32'd1);
    chk({tag, ".busy"},   32'(st[2]), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; ui8 = 8'h00; ui4 = 8'h00;
    uio_in8 = 8'h00; uio_in4 = 8'h00;
    tick(); tick();
    chk("rst.uo",     32'(uo8),    32'h00);
    chk("rst.uio",    32'(uio_o8), 32'h00);
    chk("rst.oe",     32'(oe8),    32'h0F);
    chk("rst.uo4",    32'(uo4),    32'h00);
    #3 rst_n = 1'b1;
    tick();

    // Directed cases
    op("add5a3c", 8, 'h5A, 'h3C, 1'b0, 1'b0, 0);
    op("addwrap", 8, 'hFF, 'h01, 1'b0, 1'b0, 0);
    op("sub",     8, 'h10, 'h20, 1'b0, 1'b1, 0);
    op("gapped",  8, 'h5A, 'h3C, 1'b0, 1'b0, 2);
    op("w4",      4, 'h7,  'h1,  1'b0, 1'b0, 0);
    op("addcin",  8, 'h7F, 'h00, 1'b1, 1'b0, 0);

    // Abort: restart after 4 bits
    drive(8, mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(8, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
      tick();
    end
    op("abort", 8, 'h01, 'h02, 1'b0, 1'b0, 0);

    // Reset mid-RUN
    drive(8, mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(8, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
      tick();
    end
    #1 rst_n = 1'b0;
    #1;
    chk("midrst.uo",  32'(uo8),    32'h00);
    chk("midrst.uio", 32'(uio_o8), 32'h00);
    chk("midrst.oe",  32'(oe8),    32'h0F);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(8, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
      tick();
    end
    drive(8, 8'h00);
    chk("postrst.uo",   32'(uo8),       32'h00);
    chk("postrst.busy", 32'(uio_o8[2]), 32'd0);
    chk("postrst.done", 32'(uio_o8[1]), 32'd0);

    // Randomized operations
    for (int n = 0; n < 30; n++) begin
      op("rnd8", 8, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
         1'($urandom), 1'($urandom), int'($urandom_range(0, 1)));
    end
    for (int n = 0; n < 12; n++) begin
      op("rnd4", 4, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
         1'($urandom), 1'($urandom), int'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tt_um_serial_adder.md
# tt_um_serial_adder

Parametrised bit-serial adder/subtractor: the multi-bit successor to the single-bit full adder tile. Operands arrive LSB-first, one bit pair per valid cycle. A registered carry chains the bits, and the WIDTH-bit result is assembled in a shift register. The block is the Tiny Tapeout top level and exposes result, carry-out, signed overflow and handshake status on the dedicated and bidirectional pins.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..8.
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  clock enable. When 0, all state holds.
- ui_in  input  8  [0] a_bit, [1] b_bit, [2] cin, [3] start, [4] valid, [5] sub, [7:6] unused.
- uo_out  output  8  result, zero-extended above WIDTH.
- uio_in  input  8  unused.
- uio_out  output  8  [0] cout, [1] done, [2] busy, [3] ovf, [7:4] 0.
- uio_oe  output  8  constant 8'h0F.

## Operation
- States: IDLE, RUN, DONE.
- start=1 in any state with ena=1 does the following, and start has priority over valid in the same cycle:
  - clears the result register, bit counter, cout, ovf and done;
  - latches sub;
  - sets carry to cin for add, or ~cin for sub (cin acts as borrow-in);
  - enters RUN.
- Bits are not sampled in the start cycle.
- RUN, valid=1:
  - b' = b_bit ^ sub_latched;
  - s = a ^ b' ^ carry; carry <= majority(a, b', carry);
  - result <= {s, result[WIDTH-1:1]};
  - counter increments.
- RUN, valid=0: hold everything.
- On the valid bit with counter == WIDTH-1:
  - cout <= new carry;
  - ovf <= carry_in_to_MSB ^ new carry;
  - state goes to DONE.
- DONE holds result, cout and ovf until the next start. valid is ignored in IDLE and DONE.
- Status decode: busy = (state == RUN); done = (state == DONE).
- start during RUN aborts the current operation and restarts cleanly.
- Reset mid-operation returns to IDLE immediately; partial result is discarded.

## Timing
- Reset values:
  - uo_out = 0;
  - uio_out = 0 (cout, done, busy and ovf all 0);
  - internal carry, counter and sub latch = 0;
  - uio_oe = 8'h0F always.
- All outputs are registered; no combinational path from ui_in to uo_out or uio_out.
- Latency: start at edge S; the k-th valid bit is sampled at a later edge. done=1, busy=0 and the final result are visible immediately after the edge sampling the WIDTH-th valid bit.
- Minimum operation is WIDTH+1 edges (start plus WIDTH back-to-back valid bits).
- Back-to-back operations: start may be asserted in the cycle directly after done rises.

## Configuration
- SERIAL_ADDER_SUB_EN defined: subtract mode as described; ui_in[5] is latched at start.
- SERIAL_ADDER_SUB_EN undefined:
  - sub is tied to 0 and ui_in[5] is unused;
  - b is never inverted and carry initialises to cin;
  - add behaviour, cout and ovf are unchanged.

## Structure
- Package serial_adder_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - localparams for ui_in and uio_out bit indices;
  - the UIO_OE constant 8'h0F.
- Sub-module full_adder_bit: combinational (a, b, cin) -> (s, cout), instantiated once. The top level owns the carry register, counter, shift register and FSM.

## Test plan
- Add, WIDTH=8, cin=0: 0x5A + 0x3C with 8 back-to-back valid bits -> result 0x96, cout 0, ovf 1, done 1 after the 8th bit edge.
- Add with carry wrap: 0xFF + 0x01, cin=0 -> result 0x00, cout 1, ovf 0.
- Subtract, sub=1, cin=0: 0x10 - 0x20 -> result 0xF0, cout 0 (borrow), ovf 0. Without SERIAL_ADDER_SUB_EN the same stimulus gives 0x30, cout 0.
- Gapped valid: 0x5A + 0x3C with valid low for 3 cycles between bits 3 and 4, and ena low for 2 cycles -> same result 0x96, busy held throughout.
- Abort and reset:
  - start re-asserted after 4 bits, then 0x01 + 0x02 sent -> 0x03, cout 0;
  - rst_n pulsed low mid-RUN -> all outputs 0 asynchronously, state IDLE, and valid ignored until the next start.
- WIDTH=4 instance: 0x7 + 0x1 -> uo_out 0x08, cout 0, ovf 1, done after 4 valid bits.
